// File: rtl/multi_flag_toggle_sync_pkg.sv
// Shared width helpers and types for the toggle-flag CDC receiver and its sender-side counterpart.
package multi_flag_toggle_sync_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Channel index needs at least one bit even for a single channel.
    function automatic int ch_width(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

    function automatic int cnt_width(input int pending_depth);
        return clog2(pending_depth + 1);
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } out_state_e;

endpackage

// File: rtl/multi_flag_toggle_sync_if.sv
// Valid/ready event port: the receiver presents a channel index, the sequencer accepts it.
interface multi_flag_toggle_sync_if #(
    parameter int CH_WIDTH = 2
);
    logic                event_valid;
    logic [CH_WIDTH-1:0] event_ch;
    logic                event_ready;

    modport master (output event_valid, output event_ch, input event_ready);
    modport slave  (input event_valid, input event_ch, output event_ready);
endinterface

// File: rtl/multi_flag_toggle_sync_channel.sv
// One receive channel: toggle synchroniser, edge detector, saturating pending counter, sticky overflow.
module flag_sync_channel
    import multi_flag_toggle_sync_pkg::*;
#(
    parameter int SYNC_STAGES   = 3,
    parameter int PENDING_DEPTH = 4,
    parameter int CNT_WIDTH     = cnt_width(PENDING_DEPTH)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_toggle,
    input  logic i_dec,
    input  logic i_clr,
    output logic o_nonzero,
    output logic o_overflow
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_overflow;
    logic                   w_edge;
    logic                   w_full;

    // r_last holds the previous value of the final sync stage, so the edge is seen only on settled data.
    assign w_edge = r_sync[SYNC_STAGES-1] ^ r_last;
    assign w_full = (r_cnt == CNT_WIDTH'(PENDING_DEPTH));

    // NOTE: every flop here is cleared by reset so a reset discards all in-flight events.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync     <= '0;
            r_last     <= 1'b0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so each stage samples the pre-edge value of the one before.
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_toggle};
            r_last <= r_sync[SYNC_STAGES-1];

            case ({w_edge, i_dec})
                2'b10:   if (!w_full) r_cnt <= r_cnt + CNT_WIDTH'(1);
                2'b01:   r_cnt <= r_cnt - CNT_WIDTH'(1);
                default: r_cnt <= r_cnt;
            endcase

            // A new loss outranks a clear arriving in the same cycle.
            if (w_edge && !i_dec && w_full) begin
                r_overflow <= 1'b1;
            end else if (i_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_nonzero  = (r_cnt != '0);
    assign o_overflow = r_overflow;

endmodule

// File: rtl/multi_flag_toggle_sync.sv
// N-channel toggle-flag CDC receiver: per-channel sync/count, round-robin serialiser, ACK toggle return.
module multi_flag_toggle_sync
    import multi_flag_toggle_sync_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 3,
    parameter int PENDING_DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [CHANNELS-1:0]     i_toggle,
    input  logic [CHANNELS-1:0]     i_overflow_clr,
    output logic [CHANNELS-1:0]     o_ack_toggle,
    output logic [CHANNELS-1:0]     o_pending,
    output logic [CHANNELS-1:0]     o_overflow,
    multi_flag_toggle_sync_if.master evt
);

    localparam int CH_WIDTH  = ch_width(CHANNELS);
    localparam int CNT_WIDTH = cnt_width(PENDING_DEPTH);

    logic [CHANNELS-1:0] w_nonzero;
    logic [CHANNELS-1:0] w_dec;
    logic [CHANNELS-1:0] w_ack_flip;
    logic [CH_WIDTH-1:0] w_grant;
    logic                w_any;
    logic                w_load;
    logic                w_handshake;
    int                  w_idx;
    out_state_e          w_state_nxt;

    out_state_e          r_state;
    logic [CH_WIDTH-1:0] r_ch;
    logic [CH_WIDTH-1:0] r_ptr;
    logic [CHANNELS-1:0] r_ack;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        flag_sync_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .PENDING_DEPTH (PENDING_DEPTH),
            .CNT_WIDTH     (CNT_WIDTH)
        ) u_channel (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_toggle   (i_toggle[g]),
            .i_dec      (w_dec[g]),
            .i_clr      (i_overflow_clr[g]),
            .o_nonzero  (w_nonzero[g]),
            .o_overflow (o_overflow[g])
        );
    end

    // Scan from farthest to nearest offset so the channel closest after the pointer wins.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
        w_grant = r_ptr;
        w_any   = 1'b0;
        w_idx   = 0;
        for (int off = CHANNELS; off >= 1; off--) begin
            w_idx = int'(r_ptr) + off;
            if (w_idx >= CHANNELS) w_idx = w_idx - CHANNELS;
            if (w_nonzero[w_idx]) begin
                w_grant = CH_WIDTH'(w_idx);
                w_any   = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = '0;
        w_ack_flip  = '0;
        w_handshake = (r_state == ST_HOLD) && evt.event_ready;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (evt.event_ready) begin
                    if (w_any) w_load = 1'b1;
                    else       w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_load)      w_dec[w_grant]   = 1'b1;
        if (w_handshake) w_ack_flip[r_ch] = 1'b1;
    end

    // Pointer resets to the last channel so channel 0 is searched first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_ptr   <= CH_WIDTH'(CHANNELS - 1);
            r_ack   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= r_ack ^ w_ack_flip;
            if (w_load) begin
                r_ch  <= w_grant;
                r_ptr <= w_grant;
            end
        end
    end

    assign evt.event_valid = (r_state == ST_HOLD);
    assign evt.event_ch    = r_ch;
    assign o_ack_toggle    = r_ack;
    assign o_pending       = w_nonzero;

endmodule

// File: tb/tb_multi_flag_toggle_sync.sv
// Directed bench for multi_flag_toggle_sync with 4 channels, 3 sync stages and depth 4.
module tb_multi_flag_toggle_sync;
    import multi_flag_toggle_sync_pkg::*;

    localparam int CHANNELS = 4;
    localparam int CH_WIDTH = ch_width(CHANNELS);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [CHANNELS-1:0] toggle = '0;
    logic [CHANNELS-1:0] clr = '0;
    logic [CHANNELS-1:0] ack;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] overflow;

    int n_checks = 0;
    int n_errors = 0;

    multi_flag_toggle_sync_if #(.CH_WIDTH(CH_WIDTH)) evt_if ();

    multi_flag_toggle_sync #(
        .CHANNELS      (CHANNELS),
        .SYNC_STAGES   (3),
        .PENDING_DEPTH (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_toggle       (toggle),
        .i_overflow_clr (clr),
        .o_ack_toggle   (ack),
        .o_pending      (pending),
        .o_overflow     (overflow),
        .evt            (evt_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flip(input logic [CHANNELS-1:0] mask);
        toggle = toggle ^ mask;
    endtask

    // Returns the number of falling edges until VALID is seen (20 if it never is).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (evt_if.event_valid) break;
        end
    endtask

    // Holds READY high until VALID drops; counts accepted events.
    task automatic drain(output int hs);
        hs = 0;
        evt_if.event_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!evt_if.event_valid) break;
            hs++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        evt_if.event_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int hs;
        evt_if.event_ready = 1'b0;

        // Reset state
        #2;
        check("rst_valid", evt_if.event_valid, 1'b0);
        check("rst_ch", evt_if.event_ch, 0);
        check("rst_ack", ack, 4'h0);
        check("rst_pending", pending, 4'h0);
        check("rst_overflow", overflow, 4'h0);
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        // Two events on every channel, then round-robin drain 0,1,2,3,0,1,2,3
        flip(4'hF);
        cycles(6);
        flip(4'hF);
        cycles(8);
        @(negedge clk);
        check("rr_first_valid", evt_if.event_valid, 1'b1);
        check("rr_first_ch", evt_if.event_ch, 0);
        check("rr_pending", pending, 4'hF);
        @(posedge clk);
        #1;
        evt_if.event_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rr_valid_%0d", i), evt_if.event_valid, 1'b1);
            check($sformatf("rr_ch_%0d", i), evt_if.event_ch, i % 4);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("rr_done_valid", evt_if.event_valid, 1'b0);
        check("rr_ack", ack, 4'h0);
        @(posedge clk);
        #1;

        // Single event on ch1 with READY high
        flip(4'b0010);
        wait_valid(lat);
        check("single_latency_ok", (lat >= 4 && lat <= 6), 1'b1);
        check("single_ch", evt_if.event_ch, 1);
        check("single_ack_before", ack, 4'h0);
        @(negedge clk);
        check("single_valid_drop", evt_if.event_valid, 1'b0);
        check("single_ack_after", ack, 4'b0010);
        check("single_pending", pending, 4'h0);
        @(posedge clk);
        #1;

        // Three events on ch0 while READY is low
        evt_if.event_ready = 1'b0;
        flip(4'b0001);
        cycles(6);
        flip(4'b0001);
        cycles(6);
        flip(4'b0001);
        cycles(8);
        @(negedge clk);
        check("hold_valid", evt_if.event_valid, 1'b1);
        check("hold_ch", evt_if.event_ch, 0);
        check("hold_pending", pending, 4'b0001);
        cycles(3);
        @(negedge clk);
        check("hold_ch_stable", evt_if.event_ch, 0);
        @(posedge clk);
        #1;
        drain(hs);
        check("hold_handshakes", hs, 3);
        check("hold_ack", ack, 4'b0011);

        // Overflow on ch2: 1 presented + 4 pending, the sixth is lost
        for (int k = 0; k < 5; k++) begin
            flip(4'b0100);
            cycles(6);
        end
        @(negedge clk);
        check("ovf_not_yet", overflow, 4'h0);
        check("ovf_pending", pending, 4'b0100);
        check("ovf_ch", evt_if.event_ch, 2);
        @(posedge clk);
        #1;
        flip(4'b0100);
        cycles(6);
        @(negedge clk);
        check("ovf_set", overflow, 4'b0100);
        @(posedge clk);
        #1;
        clr = 4'b0100;
        cycles(1);
        clr = '0;
        @(negedge clk);
        check("ovf_cleared", overflow, 4'h0);
        @(posedge clk);
        #1;
        flip(4'b0100);
        cycles(3);
        clr = 4'b0100;
        cycles(1);
        clr = '0;
        @(negedge clk);
        check("ovf_set_wins_over_clr", overflow, 4'b0100);
        @(posedge clk);
        #1;
        drain(hs);
        check("ovf_handshakes", hs, 5);
        check("ovf_ack", ack, 4'b0111);
        clr = 4'b0100;
        cycles(1);
        clr = '0;
        @(negedge clk);
        check("ovf_final_clear", overflow, 4'h0);
        @(posedge clk);
        #1;

        // Full ch3: edge arrives in the same cycle ch3 is loaded
        for (int k = 0; k < 5; k++) begin
            flip(4'b1000);
            cycles(6);
        end
        @(negedge clk);
        check("full_valid", evt_if.event_valid, 1'b1);
        check("full_ch", evt_if.event_ch, 3);
        check("full_pending", pending, 4'b1000);
        @(posedge clk);
        #1;
        flip(4'b1000);
        cycles(3);
        evt_if.event_ready = 1'b1;
        cycles(1);
        evt_if.event_ready = 1'b0;
        @(negedge clk);
        check("full_no_overflow", overflow, 4'h0);
        check("full_still_ch3", evt_if.event_ch, 3);
        @(posedge clk);
        #1;
        drain(hs);
        check("full_handshakes", hs, 5);
        check("full_ack", ack, 4'b0111);

        // Reset mid-operation
        flip(4'b0011);
        cycles(8);
        @(negedge clk);
        check("mid_valid", evt_if.event_valid, 1'b1);
        check("mid_pending", pending, 4'b0010);
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        check("arst_valid", evt_if.event_valid, 1'b0);
        check("arst_ch", evt_if.event_ch, 0);
        check("arst_ack", ack, 4'h0);
        check("arst_pending", pending, 4'h0);
        check("arst_overflow", overflow, 4'h0);
        toggle = '0;
        cycles(2);
        rst_n = 1'b1;
        cycles(12);
        @(negedge clk);
        check("post_rst_valid", evt_if.event_valid, 1'b0);
        check("post_rst_pending", pending, 4'h0);
        @(posedge clk);
        #1;
        flip(4'b1001);
        wait_valid(lat);
        check("post_rst_latency_ok", (lat >= 4 && lat <= 6), 1'b1);
        check("post_rst_first_ch", evt_if.event_ch, 0);
        @(posedge clk);
        #1;
        drain(hs);
        check("post_rst_handshakes", hs, 2);
        check("post_rst_ack", ack, 4'b1001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
